// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one shared memory port.
// Contested grants alternate; a stalled memory is abandoned after TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  localparam int            CW        = 10;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic          LAST_I    = 1'b0;
  localparam logic          LAST_D    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          i_err_q, i_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  // Next-state and next-output logic; acks, errs and rdata default low so they pulse for one cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = {DW{1'b0}};
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = {DW{1'b0}};

    case (state_q)
      IDLE: begin
        // Data wins when alone, or when contested and instruction was granted last
        if (d_req && (!i_req || (last_q == LAST_I))) begin
          state_d   = BUSY_D;
          last_d    = LAST_D;
          cnt_d     = {CW{1'b0}};
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (i_req) begin
          state_d   = BUSY_I;
          last_d    = LAST_I;
          cnt_d     = {CW{1'b0}};
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = {DW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = m_we_q ? {DW{1'b0}} : m_rdata;
          end
        end else if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d = 1'b1;
            i_err_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      last_q    <= LAST_I;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= {AW{1'b0}};
      m_wdata_q <= {DW{1'b0}};
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= {DW{1'b0}};
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk, rst;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int vectors     = 0;
  int miscompares = 0;

  // model state: phase 0 idle, 1 memory access outstanding, 2 response cycle
  int          ph;
  int          waited;
  bit          last_was_d;
  bit          who_d;
  logic        e_m_req, e_m_we, e_i_ack, e_i_err, e_d_ack, e_d_err;
  logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; waited = 0; last_was_d = 1'b0; who_d = 1'b0;
    e_m_req = 1'b0; e_m_we = 1'b0; e_m_addr = 32'h0; e_m_wdata = 32'h0;
    e_i_ack = 1'b0; e_i_err = 1'b0; e_i_rdata = 32'h0;
    e_d_ack = 1'b0; e_d_err = 1'b0; e_d_rdata = 32'h0;
  endtask

  // One clock edge of the arbiter's rules, evaluated on the inputs present at that edge
  task automatic model_edge();
    bit done, tout;
    e_i_ack = 1'b0; e_i_err = 1'b0; e_i_rdata = 32'h0;
    e_d_ack = 1'b0; e_d_err = 1'b0; e_d_rdata = 32'h0;
    done = 1'b0; tout = 1'b0;
    if (ph == 0) begin
      if (d_req && (!i_req || !last_was_d)) begin
        ph = 1; who_d = 1'b1; last_was_d = 1'b1; waited = 0;
        e_m_req = 1'b1; e_m_we = d_we; e_m_addr = d_addr; e_m_wdata = d_wdata;
      end else if (i_req) begin
        ph = 1; who_d = 1'b0; last_was_d = 1'b0; waited = 0;
        e_m_req = 1'b1; e_m_we = 1'b0; e_m_addr = i_addr;
      end
    end else if (ph == 1) begin
      if (m_ready) done = 1'b1;
      else begin
        waited++;
        if (waited == TO) begin done = 1'b1; tout = 1'b1; end
      end
      if (done) begin
        ph = 2; e_m_req = 1'b0;
        if (who_d) begin
          e_d_ack = 1'b1; e_d_err = tout;
          e_d_rdata = (tout || e_m_we) ? 32'h0 : m_rdata;
        end else begin
          e_i_ack = 1'b1; e_i_err = tout;
          e_i_rdata = tout ? 32'h0 : m_rdata;
        end
      end
    end else begin
      ph = 0;
    end
  endtask

  task automatic compare();
    chk("m_req", 64'(m_req), 64'(e_m_req));
    if (e_m_req) begin
      chk("m_we", 64'(m_we), 64'(e_m_we));
      chk("m_addr", 64'(m_addr), 64'(e_m_addr));
      if (who_d) chk("m_wdata", 64'(m_wdata), 64'(e_m_wdata));
    end
    chk("i_ack", 64'(i_ack), 64'(e_i_ack));
    chk("i_err", 64'(i_err), 64'(e_i_err));
    chk("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
    chk("d_ack", 64'(d_ack), 64'(e_d_ack));
    chk("d_err", 64'(d_err), 64'(e_d_err));
    chk("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, 64'(m_req), 64'h0);
    chk({tag, "_m_we"}, 64'(m_we), 64'h0);
    chk({tag, "_m_addr"}, 64'(m_addr), 64'h0);
    chk({tag, "_m_wdata"}, 64'(m_wdata), 64'h0);
    chk({tag, "_acks"}, 64'({i_ack, d_ack}), 64'h0);
    chk({tag, "_errs"}, 64'({i_err, d_err}), 64'h0);
    chk({tag, "_i_rdata"}, 64'(i_rdata), 64'h0);
    chk({tag, "_d_rdata"}, 64'(d_rdata), 64'h0);
  endtask

  // Reset asserted between edges so its effect must be asynchronous
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    chk({tag, "_held"}, 64'(m_req), 64'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : main
    int thr;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0; m_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // fetch alone, memory answers on the second busy cycle
    i_req = 1'b1; i_addr = 32'h10; m_rdata = 32'hDEADBEEF;
    step();
    chk("f_m_req", 64'(m_req), 64'h1);
    chk("f_m_addr", 64'(m_addr), 64'h10);
    chk("f_m_we", 64'(m_we), 64'h0);
    step();
    chk("f_no_ack_yet", 64'(i_ack), 64'h0);
    m_ready = 1'b1;
    step();
    chk("f_ack", 64'(i_ack), 64'h1);
    chk("f_rdata", 64'(i_rdata), 64'hDEADBEEF);
    chk("f_model_rdata", 64'(e_i_rdata), 64'hDEADBEEF);
    chk("f_err", 64'(i_err), 64'h0);
    i_req = 1'b0; m_ready = 1'b0;
    step();
    chk("f_ack_fall", 64'(i_ack), 64'h0);
    chk("f_rdata_fall", 64'(i_rdata), 64'h0);

    // store alone, m_ready already high before the grant
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A5A5A5A;
    m_ready = 1'b1; m_rdata = 32'h12345678;
    step();
    chk("s_m_we", 64'(m_we), 64'h1);
    chk("s_m_wdata", 64'(m_wdata), 64'h5A5A5A5A);
    chk("s_m_addr", 64'(m_addr), 64'h20);
    step();
    chk("s_ack", 64'(d_ack), 64'h1);
    chk("s_rdata", 64'(d_rdata), 64'h0);
    chk("s_i_ack", 64'(i_ack), 64'h0);
    d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    step();
    chk("s_ack_fall", 64'(d_ack), 64'h0);

    // contention after reset: data, then instruction, then data again
    apply_reset("rst1");
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200; m_ready = 1'b1;
    step();
    chk("c1_grant_d", 64'(m_addr), 64'h200);
    step();
    chk("c1_d_ack", 64'(d_ack), 64'h1);
    chk("c1_i_ack", 64'(i_ack), 64'h0);
    d_req = 1'b0;
    step();
    step();
    chk("c2_grant_i", 64'(m_addr), 64'h100);
    step();
    chk("c2_i_ack", 64'(i_ack), 64'h1);
    i_addr = 32'h104; d_req = 1'b1; d_addr = 32'h204;
    step();
    step();
    chk("c3_grant_d", 64'(m_addr), 64'h204);
    step();
    chk("c3_d_ack", 64'(d_ack), 64'h1);
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    step();

    // timeout on a stalled load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; m_rdata = 32'hFFFFFFFF;
    step();
    chk("t_m_req", 64'(m_req), 64'h1);
    for (int k = 0; k < TO - 1; k++) begin
      step();
      chk("t_waiting", 64'({m_req, d_ack}), 64'h2);
    end
    step();
    chk("t_m_req_drop", 64'(m_req), 64'h0);
    chk("t_ack", 64'(d_ack), 64'h1);
    chk("t_err", 64'(d_err), 64'h1);
    chk("t_rdata", 64'(d_rdata), 64'h0);
    d_req = 1'b0;
    step();
    chk("t_err_fall", 64'(d_err), 64'h0);

    // grant-time values hold while the requester changes its inputs
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hCAFEF00D;
    step();
    d_addr = 32'h500; d_wdata = 32'h0BADC0DE;
    step();
    chk("h_m_addr", 64'(m_addr), 64'h400);
    chk("h_m_wdata", 64'(m_wdata), 64'hCAFEF00D);
    m_ready = 1'b1;
    step();
    chk("h_ack", 64'(d_ack), 64'h1);
    d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    step();

    // reset in the middle of a fetch
    i_req = 1'b1; i_addr = 32'h600;
    step();
    chk("r_m_req", 64'(m_req), 64'h1);
    step();
    i_req = 1'b0;
    apply_reset("rst2");
    step();
    step();
    chk("r_no_ack", 64'(i_ack), 64'h0);
    i_req = 1'b1; i_addr = 32'h700;
    step();
    chk("r_fresh_addr", 64'(m_addr), 64'h700);
    m_ready = 1'b1; m_rdata = 32'h00C0FFEE;
    step();
    chk("r_fresh_ack", 64'(i_ack), 64'h1);
    chk("r_fresh_rdata", 64'(i_rdata), 64'h00C0FFEE);
    i_req = 1'b0; m_ready = 1'b0;
    step();

    // random traffic with varying memory latency, including stretches that time out
    thr = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: thr = 0;
          1: thr = 2;
          2: thr = 5;
          default: thr = 10;
        endcase
      end
      m_ready = ($urandom_range(0, 9) < thr);
      m_rdata = $urandom;
      if (i_req && e_i_ack) begin
        i_req = ($urandom_range(0, 3) == 0);
        i_addr = $urandom;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = $urandom;
      end
      if (d_req && e_d_ack) begin
        d_req = ($urandom_range(0, 3) == 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 3) == 0) begin
        d_addr = $urandom; d_wdata = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter AW, default 32, meaning the address width in bits.
REQ-002 The block SHALL take parameter DW, default 32, meaning the data width in bits.
REQ-003 The block SHALL take parameter TIMEOUT, default 255, meaning the maximum number of wait cycles for m_ready before a transfer is aborted (range 1..1023).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 i_req  input  1: instruction-fetch request, level, held until i_ack.
REQ-007 i_addr  input  AW: fetch address, stable while i_req=1.
REQ-008 i_rdata  output  DW: fetched word, valid only while i_ack=1.
REQ-009 i_ack  output  1: one-cycle fetch completion pulse.
REQ-010 i_err  output  1: one-cycle timeout flag, asserted together with i_ack.
REQ-011 d_req  input  1: data request, level, held until d_ack.
REQ-012 d_we  input  1: 1=store, 0=load, stable while d_req=1.
REQ-013 d_addr  input  AW: data address.
REQ-014 d_wdata  input  DW: store data.
REQ-015 d_rdata  output  DW: load data, valid only while d_ack=1.
REQ-016 d_ack  output  1: one-cycle data completion pulse.
REQ-017 d_err  output  1: one-cycle timeout flag, asserted together with d_ack.
REQ-018 m_req  output  1: shared-memory request, held high until m_ready or timeout.
REQ-019 m_we  output  1: write strobe to shared memory.
REQ-020 m_addr  output  AW: shared-memory address.
REQ-021 m_wdata  output  DW: shared-memory write data.
REQ-022 m_rdata  input  DW: shared-memory read data, valid in the cycle m_ready=1.
REQ-023 m_ready  input  1: shared-memory completion, sampled only while m_req=1.

Function
REQ-024 The FSM SHALL have states IDLE, BUSY_I, BUSY_D and RESP.
REQ-025 IDLE: i_req only -> BUSY_I; d_req only -> BUSY_D; neither -> stay.
REQ-026 IDLE with i_req and d_req both high: grant the requester NOT granted last (round-robin); the last-grant flag resets to "instruction", so the first contested grant goes to data.
REQ-027 On the grant edge the block SHALL latch the winner's address, write data and write enable into m_addr, m_wdata and m_we, and SHALL set m_req=1; a fetch always forces m_we=0.
REQ-028 In BUSY_x, m_addr, m_wdata and m_we SHALL remain constant regardless of requester inputs.
REQ-029 In BUSY_x, m_ready=1 sampled at an edge: capture m_rdata into the granted rdata output, clear m_req, and go to RESP.
REQ-030 A wait counter SHALL clear on grant and increment each BUSY cycle with m_ready=0; when it reaches TIMEOUT: clear m_req, set rdata to 0, set the err flag, and go to RESP.
REQ-031 RESP SHALL last exactly one cycle with the granted ack=1 (and err if timed out), then go to IDLE; requests are not sampled in RESP.
REQ-032 The non-granted requester's ack, err and rdata SHALL stay 0 throughout; rdata outputs SHALL return to 0 when ack falls.
REQ-033 All outputs SHALL be registered; minimum turnaround is grant, at least one BUSY cycle, then RESP, so back-to-back transfers are at least 3 cycles apart.
REQ-034 m_ready while m_req=0 SHALL be ignored.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, clear the wait counter, set last-grant to instruction, and drive every output (m_req, m_we, m_addr, m_wdata, acks, errs, rdata) to 0, including mid-transfer.
REQ-036 After rst rises, the first grant decision SHALL occur at the first rising clk edge with a request present.

Verification
REQ-037 Fetch alone: i_req=1, i_addr=0x10, m_ready on the 2nd BUSY cycle with m_rdata=0xDEADBEEF -> m_addr=0x10, m_we=0, i_ack one cycle with i_rdata=0xDEADBEEF, i_err=0.
REQ-038 Store alone: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x5A5A5A5A, immediate m_ready -> m_we=1, m_wdata=0x5A5A5A5A, d_ack one cycle, d_rdata=0.
REQ-039 Contention after reset: i_req and d_req high together in the same cycle -> data served first; instruction served next; a further simultaneous pair -> data again (alternation).
REQ-040 Timeout: TIMEOUT=4, d_req load, m_ready held at 0 -> m_req drops after 4 wait cycles, d_ack=1 and d_err=1 for one cycle, d_rdata=0.
REQ-041 Reset mid-transfer: rst=0 during BUSY_I -> m_req=0 and all outputs 0 asynchronously; no i_ack after rst rises; a fresh i_req is then served normally.
REQ-042 Stability: change d_addr and d_wdata while BUSY_D -> m_addr and m_wdata keep the values latched at grant.
